// File: rtl/wb_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_if
// Brief    : Pipelined Wishbone bus bundle (32-bit address/data, 4 byte selects)
// Revision : 1.0 - initial release
// ============================================================================
interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] dat_s;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  stall, ack, err, dat_s
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output stall, ack, err, dat_s
    );
endinterface
`default_nettype wire

// File: rtl/wb_arb2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb2
// Brief    : Two-master pipelined Wishbone arbiter with outstanding-request
//            limit. Define WB_ARB2_ROUND_ROBIN_EN for round-robin tie-break.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb2 #(
    parameter int MAX_OUTST = 4
) (
    input  logic  clk,
    input  logic  rst,
    wb_if.slave   m0,
    wb_if.slave   m1,
    wb_if.master  s
);

    localparam int                 c_cnt_w   = $clog2(MAX_OUTST + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_OUTST);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_gnt0 = 2'd1;
    localparam logic [1:0] c_st_gnt1 = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_upd;
    logic               r_discard;
    logic               w_pick_m1;
    logic               w_gnt;
    logic               w_release;
    logic               w_full;
    logic               w_accept;
    logic               w_resp;
    logic               w_inc;
    logic               w_dec;

    logic               w_s_cyc;
    logic               w_s_stb;
    logic               w_s_we;
    logic [31:0]        w_s_adr;
    logic [3:0]         w_s_sel;
    logic [31:0]        w_s_dat_m;

`ifdef WB_ARB2_ROUND_ROBIN_EN
    logic r_last_m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_m1 <= 1'b1;
        end else if (r_state == c_st_idle && w_state_nxt != c_st_idle) begin
            r_last_m1 <= (w_state_nxt == c_st_gnt1);
        end
    end

    assign w_pick_m1 = !r_last_m1;
`else
    assign w_pick_m1 = 1'b1;
`endif

    assign w_gnt     = (r_state == c_st_gnt0) || (r_state == c_st_gnt1);
    assign w_release = w_gnt && (w_state_nxt == c_st_idle);
    assign w_full    = (r_cnt == c_cnt_max);
    assign w_accept  = w_s_cyc && w_s_stb && !s.stall;
    // Responses only count while a grant is live and no stale reply is pending
    assign w_resp    = w_gnt && !r_discard && (s.ack || s.err);
    assign w_inc     = w_accept && !w_full;
    assign w_dec     = w_resp && (r_cnt != '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (grant is non-preemptive)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (m0.cyc && m1.cyc) begin
                    w_state_nxt = w_pick_m1 ? c_st_gnt1 : c_st_gnt0;
                end else if (m1.cyc) begin
                    w_state_nxt = c_st_gnt1;
                end else if (m0.cyc) begin
                    w_state_nxt = c_st_gnt0;
                end
            end
            c_st_gnt0: begin
                if (!m0.cyc) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_gnt1: begin
                if (!m1.cyc) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_s_cyc   = 1'b0;
        w_s_stb   = 1'b0;
        w_s_we    = 1'b0;
        w_s_adr   = '0;
        w_s_sel   = '0;
        w_s_dat_m = '0;
        m0.stall  = 1'b1;
        m0.ack    = 1'b0;
        m0.err    = 1'b0;
        m1.stall  = 1'b1;
        m1.ack    = 1'b0;
        m1.err    = 1'b0;
        case (r_state)
            c_st_gnt0: begin
                w_s_cyc   = m0.cyc;
                w_s_stb   = m0.stb && !w_full;
                w_s_we    = m0.we;
                w_s_adr   = m0.adr;
                w_s_sel   = m0.sel;
                w_s_dat_m = m0.dat_m;
                m0.stall  = s.stall || w_full;
                m0.ack    = s.ack && !r_discard;
                m0.err    = s.err && !r_discard;
            end
            c_st_gnt1: begin
                w_s_cyc   = m1.cyc;
                w_s_stb   = m1.stb && !w_full;
                w_s_we    = m1.we;
                w_s_adr   = m1.adr;
                w_s_sel   = m1.sel;
                w_s_dat_m = m1.dat_m;
                m1.stall  = s.stall || w_full;
                m1.ack    = s.ack && !r_discard;
                m1.err    = s.err && !r_discard;
            end
            default: begin
            end
        endcase
    end

    assign s.cyc    = w_s_cyc;
    assign s.stb    = w_s_stb;
    assign s.we     = w_s_we;
    assign s.adr    = w_s_adr;
    assign s.sel    = w_s_sel;
    assign s.dat_m  = w_s_dat_m;
    assign m0.dat_s = s.dat_s;
    assign m1.dat_s = s.dat_s;

    // ------------------------------------------------------------------
    // Outstanding counter and stale-response discard flag
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_upd = r_cnt;
        if (w_inc && !w_dec) begin
            w_cnt_upd = r_cnt + c_cnt_one;
        end else if (w_dec && !w_inc) begin
            w_cnt_upd = r_cnt - c_cnt_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_discard <= 1'b0;
        end else if (w_release) begin
            r_cnt     <= '0;
            // Replies still in flight must not reach the next owner
            r_discard <= (w_cnt_upd != '0);
        end else begin
            r_cnt <= w_cnt_upd;
            if (w_accept) begin
                r_discard <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 Parameter MAX_OUTST, default 4, maximum accepted-but-unacknowledged requests per grant (1..15).
REQ-002 clk  input  1  single clock, all state on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 m0  wb_if.slave  -  master port 0, instruction side: cyc, stb, we, adr[31:0], sel[3:0], dat_m[31:0] in; stall, ack, err, dat_s[31:0] out.
REQ-005 m1  wb_if.slave  -  master port 1, data side, same signal set as m0.
REQ-006 s  wb_if.master  -  shared pipelined Wishbone slave port: cyc, stb, we, adr, sel, dat_m out; stall, ack, err, dat_s in.

Function
REQ-007 FSM states: IDLE, GNT0, GNT1; the owner is m0 in GNT0 and m1 in GNT1, with no owner in IDLE.
REQ-008 IDLE: s.cyc=0, s.stb=0; m0.stall=m1.stall=1; no acks/errs forwarded.
REQ-009 IDLE -> GNTx on the cycle after any mx.cyc=1 seen in IDLE, winner per REQ-016; grant latency exactly 1 cycle.
REQ-010 GNTx: s.cyc/stb/we/adr/sel/dat_m = mx.* combinationally; mx.stall=s.stall, mx.ack=s.ack, mx.err=s.err, mx.dat_s=s.dat_s.
REQ-011 Non-owner in GNTx: stall=1, ack=0, err=0; dat_s=s.dat_s (don't-care).
REQ-012 Outstanding counter (width clog2(MAX_OUTST+1)): +1 on s.cyc&s.stb&!s.stall, -1 on s.ack|s.err, unchanged when both occur in the same cycle.
REQ-013 Counter==MAX_OUTST: s.stb forced 0 and owner stall forced 1 until a decrement occurs; the counter never exceeds MAX_OUTST or underflows below 0.
REQ-014 GNTx -> IDLE on the cycle after mx.cyc=0; counter cleared on that transition; at least one IDLE cycle separates two grants.
REQ-015 Owner drops cyc with counter!=0: release still occurs; late s.ack/s.err arriving in IDLE or in the other grant before the new owner's first accepted stb are discarded (not forwarded, no decrement).
REQ-016 Arbitration: both cyc asserted in IDLE -> m1 wins; a single requester always wins.
REQ-017 Grant is non-preemptive; a request from the other master never shortens the current grant.
REQ-018 Output stability: while owner stb=1 and stall=1, s.adr/we/sel/dat_m stay stable, provided the owner holds them stable.

Reset
REQ-019 rst=1 asynchronously forces: state IDLE, counter 0, last-grant register = m1, discard flag 0.
REQ-020 Outputs during and after reset until first grant: s.cyc=0, s.stb=0, m0.stall=m1.stall=1, m0/m1 ack=0, err=0.
REQ-021 Reset mid-transaction aborts the cycle; no ack/err forwarded after reset assertion; post-reset arbitration restarts per REQ-009.

Configuration
REQ-022 Macro WB_ARB2_ROUND_ROBIN_EN defined: simultaneous requests in IDLE grant the master not granted last; after reset m0 wins first.
REQ-023 Macro undefined: fixed priority per REQ-016; last-grant register is absent.
REQ-024 All other behaviour is identical with and without the macro.

Verification
REQ-025 Single read: m0 cyc/stb, adr=0x0000_1000, s.stall=0, s.ack two cycles later with dat_s=0xDEAD_BEEF -> GNT0 one cycle after request; m0.ack with 0xDEAD_BEEF; m1.stall=1 throughout.
REQ-026 Contention: m0 and m1 cyc in the same cycle -> no macro: m1 granted, m0 granted after m1 drops cyc plus one IDLE cycle; with macro: m0 first, then m1.
REQ-027 Burst saturation: MAX_OUTST=4, m1 issues 6 writes, s.ack withheld -> exactly 4 accepted, s.stb=0 and m1.stall=1 until the first ack, then the remaining 2 issued.
REQ-028 Ack+accept same cycle at counter=2 -> counter stays 2; err on the 3rd of 3 reads -> m1.err=1, m1.ack=0 on that cycle, counter reaches 0.
REQ-029 Early release: m0 drops cyc with 1 outstanding, m1 requesting, stale s.ack in the next cycle -> stale ack not seen on m0 or m1; m1 granted normally.
REQ-030 Async reset asserted mid-burst between clock edges -> s.cyc=0 and both stalls=1 immediately, without waiting for a clock edge; clean grant after release.
